// File: rtl/pmem_arbiter.sv
// Two-client physical-memory arbiter: routes the I-cache or D-cache line
// traffic onto one memory port, round-robin when both request in IDLE.
module pmem_arbiter (
  input  logic         clk,
  input  logic         reset,

  input  logic [15:0]  i_pmem_address,
  input  logic         i_pmem_read,
  output logic [127:0] i_pmem_rdata,
  output logic         i_pmem_resp,

  input  logic [15:0]  d_pmem_address,
  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [127:0] d_pmem_wdata,
  output logic [127:0] d_pmem_rdata,
  output logic         d_pmem_resp,

  output logic [15:0]  mem_address,
  output logic         mem_read,
  output logic         mem_write,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t state, state_next;
  logic   last_grant, last_grant_next;
  logic   i_req, d_req;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  // Outputs decode from the registered state only, so a request seen in
  // IDLE reaches the memory port one cycle later and reset clears it at once.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    mem_address     = '0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_wdata       = d_pmem_wdata;
    i_pmem_resp     = 1'b0;
    d_pmem_resp     = 1'b0;

    unique case (state)
      IDLE: begin
        if (i_req && d_req) begin
          state_next = (last_grant == GRANT_I) ? SERVE_D : SERVE_I;
        end else if (i_req) begin
          state_next = SERVE_I;
        end else if (d_req) begin
          state_next = SERVE_D;
        end
      end

      SERVE_I: begin
        mem_address = i_pmem_address;
        mem_read    = i_pmem_read;
        i_pmem_resp = mem_resp;
        if (mem_resp) begin
          state_next      = IDLE;
          last_grant_next = GRANT_I;
        end
      end

      SERVE_D: begin
        mem_address = d_pmem_address;
        mem_write   = d_pmem_write;
        mem_read    = d_pmem_read & ~d_pmem_write;
        d_pmem_resp = mem_resp;
        if (mem_resp) begin
          state_next      = IDLE;
          last_grant_next = GRANT_D;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/pmem_arbiter.md
PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 The module SHALL have one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high; forces the reset state of REQ-020 immediately.
REQ-004 i_pmem_address  in  16  I-cache line address (lc3b_word).
REQ-005 i_pmem_read  in  1  I-cache line-fill request.
REQ-006 i_pmem_rdata  out  128  line data to the I-cache (lc3b_memband).
REQ-007 i_pmem_resp  out  1  completion pulse to the I-cache.
REQ-008 d_pmem_address  in  16  D-cache line address.
REQ-009 d_pmem_read  in  1  D-cache line-fill request.
REQ-010 d_pmem_write  in  1  D-cache dirty-line writeback request.
REQ-011 d_pmem_wdata  in  128  D-cache writeback line.
REQ-012 d_pmem_rdata  out  128  line data to the D-cache.
REQ-013 d_pmem_resp  out  1  completion pulse to the D-cache.
REQ-014 mem_address  out  16  address to physical memory.
REQ-015 mem_read  out  1  read strobe to physical memory.
REQ-016 mem_write  out  1  write strobe to physical memory.
REQ-017 mem_wdata  out  128  write line to physical memory.
REQ-018 mem_rdata  in  128  read line from physical memory.
REQ-019 mem_resp  in  1  physical memory completion, one cycle per transaction.

Function
REQ-020 The FSM SHALL have three states: IDLE, SERVE_I and SERVE_D. It SHALL also hold a last_grant bit (I=0, D=1).
REQ-021 In IDLE, the arbiter SHALL drive mem_read=0, mem_write=0 and mem_address=0. i_pmem_resp and d_pmem_resp SHALL both be 0.
REQ-022 IDLE transitions:
- Only the I-cache requesting (i_pmem_read) SHALL move the FSM to SERVE_I.
- Only the D-cache requesting (d_pmem_read|d_pmem_write) SHALL move the FSM to SERVE_D.
- Both requesting SHALL grant the side opposite last_grant (round-robin).
- No request SHALL keep the FSM in IDLE.
REQ-023 Arbitration latency SHALL be exactly one cycle: a request seen in IDLE reaches the mem_* outputs in the next cycle.
REQ-024 In SERVE_I:
- mem_address SHALL equal i_pmem_address.
- mem_read SHALL equal i_pmem_read.
- mem_write SHALL be 0.
- mem_wdata SHALL be don't-care, driven as d_pmem_wdata.
REQ-025 In SERVE_D:
- mem_address SHALL equal d_pmem_address.
- mem_write SHALL equal d_pmem_write.
- mem_read SHALL equal d_pmem_read & ~d_pmem_write (write wins if both are asserted).
- mem_wdata SHALL equal d_pmem_wdata.
REQ-026 mem_rdata SHALL drive both i_pmem_rdata and d_pmem_rdata combinationally at all times.
REQ-027 mem_resp SHALL be routed combinationally to only the granted requester's resp. The non-granted resp SHALL be 0 in every cycle.
REQ-028 On a cycle in SERVE_x with mem_resp=1:
- The FSM SHALL go to IDLE at the next edge.
- last_grant SHALL be set to x.
REQ-029 The grant SHALL be held until mem_resp, even if the granted requester deasserts its request mid-transaction. This case is a protocol violation; the arbiter SHALL NOT abort or re-grant.
REQ-030 A mem_resp arriving in IDLE SHALL be ignored: no resp output and no state change.
REQ-031 A request from the other cache during SERVE_x SHALL wait, unacknowledged, until the arbiter next enters IDLE. Back-to-back transactions SHALL therefore be separated by exactly one IDLE cycle.
REQ-032 A D-cache writeback followed by its line fill SHALL be two separate grants. The I-cache may win the IDLE cycle between them if last_grant=D.

Reset
REQ-033 While reset=1, the following SHALL hold, independent of clk:
- state=IDLE.
- last_grant=I, so the D-cache wins the first contention.
- All mem_* strobes and both resp outputs SHALL be 0.
REQ-034 Reset asserted mid-transaction SHALL drop mem_read/mem_write immediately. No resp SHALL be issued for the aborted transaction.
REQ-035 After reset deasserts, the first grant SHALL occur no earlier than the first rising edge with reset=0.

Verification
REQ-036 I-only read: i_pmem_read=1, addr 0x1230; memory responds 3 cycles after mem_read.
- Cycle 1: mem_read=1, mem_address=0x1230.
- i_pmem_resp SHALL pulse with the mem_resp cycle.
- i_pmem_rdata SHALL equal mem_rdata.
- The next cycle SHALL be IDLE.
REQ-037 Simultaneous requests out of reset: i read 0x0100 and d read 0x0200.
- D SHALL be served first.
- After d_pmem_resp, one IDLE cycle SHALL follow.
- Then I SHALL be served at 0x0100.
REQ-038 Fairness: both sides request continuously for 4 transactions.
- Grants SHALL alternate D, I, D, I.
- No resp SHALL be issued to the non-granted side.
REQ-039 D writeback: d_pmem_write=1, wdata=0xA5..A5, addr 0x4440.
- mem_write=1 and mem_wdata SHALL match.
- mem_read SHALL be 0 even if d_pmem_read=1 concurrently.
REQ-040 Reset during SERVE_I, before mem_resp:
- Strobes SHALL be 0 immediately.
- state SHALL be IDLE.
- A late mem_resp SHALL produce no i_pmem_resp.
REQ-041 Stray mem_resp in IDLE: both resp outputs SHALL stay 0 and the FSM SHALL stay in IDLE.
